// File: rtl/mult_control.sv
// mult_control: control sequencer for a shift-add multiplier datapath.
// When start is seen in IDLE, the block issues one load pulse. It then runs N
// examine/add/shift iterations. Each iteration is steered by q0, the current
// multiplier bit in the datapath. After the last shift it issues a one-cycle
// done pulse.
//
// Ports
//   clk    in   rising-edge clock
//   reset  in   synchronous active-high reset
//   start  in   begin a multiply (only looked at in IDLE)
//   q0     in   datapath register bit 0 (only looked at in EXAMINE)
//   load   out  clear accumulator and load multiplier
//   add    out  capture {carry,sum} into upper register half
//   shift  out  logical right shift of the datapath register
//   busy   out  high in every legal state except IDLE
//   done   out  one-cycle pulse, product valid in the datapath
//
// All outputs are decoded from the state register only (Moore).
module mult_control #(
  parameter int N  = 4,
  parameter int CW = $clog2(N + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic q0,
  output logic load,
  output logic add,
  output logic shift,
  output logic busy,
  output logic done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_EXAM  = 3'd2,
    S_ADD   = 3'd3,
    S_SHIFT = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Next-state logic and iteration counter.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_LOAD;
      S_LOAD: begin
        count_d = '0;
        state_d = S_EXAM;
      end
      S_EXAM:  state_d = q0 ? S_ADD : S_SHIFT;
      S_ADD:   state_d = S_SHIFT;
      S_SHIFT: begin
        count_d = count_q + CW'(1);
        // The counter leaves SHIFT at N-1, so it never wraps.
        state_d = (count_q == CW'(N - 1)) ? S_DONE : S_EXAM;
      end
      S_DONE:  state_d = S_IDLE;
      // Unused encodings fall back to IDLE on the next edge.
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode. Unused encodings drive every output low.
  always_comb begin
    load  = 1'b0;
    add   = 1'b0;
    shift = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state_q)
      S_LOAD:  begin load  = 1'b1; busy = 1'b1; end
      S_EXAM:  begin               busy = 1'b1; end
      S_ADD:   begin add   = 1'b1; busy = 1'b1; end
      S_SHIFT: begin shift = 1'b1; busy = 1'b1; end
      S_DONE:  begin done  = 1'b1; busy = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mult_control.sv
// Bench for mult_control. It includes a small shift-add datapath model that
// responds to the strobes. Expected products, latencies and strobe sequences
// are worked out from the multiplier bits with plain arithmetic.
module tb_mult_control;
  localparam int N = 4;

  logic clk = 1'b0;
  logic reset, start, q0;
  logic load, add, shift, busy, done;

  int total = 0;
  int bad   = 0;

  // Datapath model state: {carry, upper half, lower half}.
  logic [2*N:0] dp_q = '0;
  int md = 0;  // multiplicand
  int mr = 0;  // multiplier

  always #5 clk = ~clk;

  mult_control #(.N(N)) dut (
    .clk(clk), .reset(reset), .start(start), .q0(q0),
    .load(load), .add(add), .shift(shift), .busy(busy), .done(done)
  );

  assign q0 = dp_q[0];

  always @(posedge clk) begin
    if (load)       dp_q <= {{(N+1){1'b0}}, mr[N-1:0]};
    else if (add)   dp_q[2*N:N] <= {1'b0, dp_q[2*N-1:N]} + (N+1)'(md);
    else if (shift) dp_q <= dp_q >> 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Strobe code: 0 idle, 1 load, 2 examine, 3 add, 4 shift, 5 done, 9 overlap.
  function automatic int code();
    int n;
    n = int'(load) + int'(add) + int'(shift) + int'(done);
    if (n > 1) return 9;
    if (done)  return 5;
    if (shift) return 4;
    if (add)   return 3;
    if (load)  return 1;
    if (busy)  return 2;
    return 0;
  endfunction

  // The strobes must never overlap on any cycle.
  always @(negedge clk) begin
    total++;
    if (int'(load) + int'(add) + int'(shift) + int'(done) > 1) begin
      bad++;
      $display("FAIL onehot: load=%0b add=%0b shift=%0b done=%0b required at most one",
               load, add, shift, done);
    end
  end

  // Run one multiply and check it against the expected values passed in.
  // If poke is set, start is pulsed again at cycle 5 while the block is busy.
  task automatic run_mult(input int mc, input int mp, input int exp_prod,
                          input int exp_lat, input int exp_adds, input bit poke);
    int exp_seq[$];
    int cyc, adds, c, loads;
    bit seq_ok, busy_ok, got_done;
    exp_seq.push_back(1);
    for (int i = 0; i < N; i++) begin
      exp_seq.push_back(2);
      if ((mp >> i) & 1) exp_seq.push_back(3);
      exp_seq.push_back(4);
    end
    exp_seq.push_back(5);
    md = mc; mr = mp;
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cyc = 0; adds = 0; seq_ok = 1; busy_ok = 1; got_done = 0;
    while (!got_done && cyc < 60) begin
      @(negedge clk);
      cyc++;
      start = (poke && cyc == 5);
      c = code();
      if (cyc > exp_seq.size() || c != exp_seq[cyc-1]) seq_ok = 0;
      if (!busy) busy_ok = 0;
      if (add) adds++;
      if (done) got_done = 1;
    end
    start = 1'b0;
    chk($sformatf("latency %0d*%0d", mc, mp), cyc, exp_lat);
    chk($sformatf("sequence %0d*%0d", mc, mp), int'(seq_ok), 1);
    chk($sformatf("busy %0d*%0d", mc, mp), int'(busy_ok), 1);
    chk($sformatf("adds %0d*%0d", mc, mp), adds, exp_adds);
    chk($sformatf("product %0d*%0d", mc, mp), int'(dp_q[2*N-1:0]), exp_prod);
    @(negedge clk);
    chk("idle after done", code(), 0);
    if (poke) begin
      loads = 0;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        if (load || busy) loads++;
      end
      chk("no queued start", loads, 0);
    end
  endtask

  typedef struct {
    int mc; int mp; int prod; int lat; int adds;
  } vec_t;

  initial begin
    vec_t vecs[$];
    int cyc, adds, dones, mc, mp;
    vecs.push_back('{8, 9, 72, 12, 2});
    vecs.push_back('{5, 0, 0, 10, 0});
    vecs.push_back('{15, 15, 225, 14, 4});
    vecs.push_back('{1, 1, 1, 11, 1});
    vecs.push_back('{7, 8, 56, 11, 1});
    vecs.push_back('{0, 6, 0, 12, 2});
    vecs.push_back('{12, 10, 120, 12, 2});

    // Reset, with start held high during it.
    reset = 1'b1; start = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset outputs", code(), 0);
    reset = 1'b0; start = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("post-reset idle", code(), 0);
    end

    foreach (vecs[i])
      run_mult(vecs[i].mc, vecs[i].mp, vecs[i].prod, vecs[i].lat, vecs[i].adds, 1'b0);

    // A start pulse while busy is ignored.
    run_mult(3, 9, 27, 12, 2, 1'b1);

    // Reset during the second ADD of 15*15.
    md = 15; mr = 15;
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cyc = 0; adds = 0;
    while (adds < 2 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (add) adds++;
    end
    chk("reached second add", adds, 2);
    reset = 1'b1;
    @(negedge clk);
    chk("abort to idle", code(), 0);
    chk("abort busy", int'(busy), 0);
    reset = 1'b0;
    dones = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    chk("no done after abort", dones, 0);
    run_mult(15, 15, 225, 14, 4, 1'b0);

    // Random multiplies checked against plain arithmetic.
    repeat (20) begin
      mc = int'($urandom_range(0, (1 << N) - 1));
      mp = int'($urandom_range(0, (1 << N) - 1));
      run_mult(mc, mp, mc * mp, 2 + 2*N + $countones(mp), $countones(mp), 1'b0);
    end

    // Hold start high: back-to-back multiplies with exactly one IDLE cycle between them.
    md = 6; mr = 5;
    @(negedge clk) start = 1'b1;
    cyc = 0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("held start first done", int'(done), 1);
    @(negedge clk);
    chk("held start gap idle", code(), 0);
    @(negedge clk);
    chk("held start reload", code(), 1);
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("held start second latency", cyc, 2 + 2*N + 2);
    chk("held start product", int'(dp_q[2*N-1:0]), 30);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
